// File: rtl/add_seq_arb_64.sv
// Two-requester arbiter that serializes WIDTH-bit additions through an external
// SLICE-bit combinational adder, one slice per clock, with round-robin grant.
module add_seq_arb_64 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x1,
  input  logic [WIDTH-1:0] req0_x2,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x1,
  input  logic [WIDTH-1:0] req1_x2,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic [SLICE-1:0] add_x1,
  output logic [SLICE-1:0] add_x2,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_s,
  input  logic             add_cout
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic             r_ptr;
  logic             r_id;
  logic             r_cout;
  logic             r_cin;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_x2;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic             w_last;

  assign w_acc  = w_gnt0 | w_gnt1;
  assign w_last = (r_k == K_LAST);

  // Grant is combinational from valids and pointer, and held off while in reset.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt0 = rst_n & req0_valid & (~req1_valid | ~r_ptr);
        w_gnt1 = rst_n & req1_valid & (~req0_valid | r_ptr);
        if (w_gnt0 | w_gnt1) w_next = BUSY;
      end
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    add_x1  = '0;
    add_x2  = '0;
    add_cin = 1'b0;
    if (r_state == BUSY) begin
      add_x1  = r_x1[r_k*SLICE +: SLICE];
      add_x2  = r_x2[r_k*SLICE +: SLICE];
      add_cin = (r_k == '0) ? r_cin : r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_cout  <= 1'b0;
      r_s     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_k   <= '0;
            r_id  <= w_gnt1;
            r_ptr <= w_gnt0;
          end
        end
        BUSY: begin
          r_s[r_k*SLICE +: SLICE] <= add_s;
          r_carry                 <= add_cout;
          r_k                     <= w_last ? '0 : r_k + KW'(1);
          if (w_last) r_cout <= add_cout;
        end
        default: ;
      endcase
    end
  end

  // Operand capture needs no reset: it is only read after an accept.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_acc) begin
      r_x1  <= w_gnt1 ? req1_x1  : req0_x1;
      r_x2  <= w_gnt1 ? req1_x2  : req0_x2;
      r_cin <= w_gnt1 ? req1_cin : req0_cin;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = (r_state == DONE);
  assign rsp_s      = r_s;
  assign rsp_cout   = r_cout;
  assign rsp_id     = r_id;

endmodule

// File: tb/tb_add_seq_arb_64.sv
// Bench for add_seq_arb_64: directed corner cases plus randomized traffic,
// checked against a whole-word addition model with a round-robin pointer.
module tb_add_seq_arb_64;

  localparam int W = 64;
  localparam int S = 16;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_x1, req0_x2;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_x1, req1_x2;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_s;
  logic [S-1:0] add_x1, add_x2, add_s;
  logic         add_cin, add_cout;

  int           checks = 0;
  int           errors = 0;
  logic         ptr_m;
  logic [W-1:0] mx1 [2];
  logic [W-1:0] mx2 [2];
  logic         mcin [2];

  always #5 clk = ~clk;

  // The shared slice adder lives outside the DUT.
  assign {add_cout, add_s} = {1'b0, add_x1} + {1'b0, add_x2} + {{S{1'b0}}, add_cin};

  add_seq_arb_64 #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1),
    .req0_x2(req0_x2), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1),
    .req1_x2(req1_x2), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .add_x1(add_x1), .add_x2(add_x2), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id);
    if (id == 0) begin
      req0_x1 = mx1[0]; req0_x2 = mx2[0]; req0_cin = mcin[0]; req0_valid = 1'b1;
    end else begin
      req1_x1 = mx1[1]; req1_x2 = mx2[1]; req1_cin = mcin[1]; req1_valid = 1'b1;
    end
  endtask

  // Called at a negedge with the DUT idle and requester id expected to win.
  task automatic serve(input int id, input int hold);
    logic [W:0]   full;
    logic [W-1:0] x1;
    int           n;
    x1   = mx1[id];
    full = {1'b0, mx1[id]} + {1'b0, mx2[id]} + {{W{1'b0}}, mcin[id]};
    #1;
    chk("grant_ready0", req0_ready, id == 0);
    chk("grant_ready1", req1_ready, id == 1);
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    ptr_m = (id == 0);
    n = 0;
    while (!rsp_valid && n < 3 * N) begin
      if (n < N) chk("slice_x1", add_x1, x1[n*S +: S]);
      if (n == 0) chk("slice0_cin", add_cin, mcin[id]);
      chk("busy_ready", req0_ready | req1_ready, 0);
      @(negedge clk);
      n++;
    end
    chk("latency", n, N);
    chk("rsp_s", rsp_s, full[W-1:0]);
    chk("rsp_cout", rsp_cout, full[W]);
    chk("rsp_id", rsp_id, id);
    chk("idle_add_x1", add_x1, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_s", rsp_s, full[W-1:0]);
      chk("hold_ready", req0_ready | req1_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("consumed", rsp_valid, 0);
    chk("no_accept_on_done_edge", add_x1 | add_x2, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  mode, win;
    logic drop;
    rst_n = 1'b0; rsp_ready = 1'b0; ptr_m = 1'b0;
    req0_valid = 1'b1; req0_x1 = '0; req0_x2 = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_x1 = '0; req1_x2 = '0; req1_cin = 1'b0;
    #3;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_s", rsp_s, 0);
    chk("rst_cout_id", {rsp_cout, rsp_id}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters on the first cycle out of reset
    for (int j = 0; j < 2; j++) begin
      mx1[j] = '1; mx2[j] = '1; mcin[j] = 1'b1;
      drive(j);
    end
    serve(0, 0);
    serve(1, 0);

    mx1[0] = 64'd999; mx2[0] = '1; mcin[0] = 1'b1;
    drive(0);
    serve(0, 0);

    mx1[1] = 64'h0000_0000_0000_FFFF; mx2[1] = 64'd1; mcin[1] = 1'b0;
    drive(1);
    serve(1, 3);

    for (int it = 0; it < 24; it++) begin
      for (int j = 0; j < 2; j++) begin
        mx1[j]  = {$urandom, $urandom};
        mx2[j]  = ($urandom_range(0, 3) == 0) ? ~mx1[j] : {$urandom, $urandom};
        mcin[j] = 1'($urandom_range(0, 1));
      end
      mode = $urandom_range(0, 2);
      if (mode < 2) begin
        drive(mode);
        serve(mode, $urandom_range(0, 2));
      end else begin
        drive(0);
        drive(1);
        win  = ptr_m ? 1 : 0;
        drop = ($urandom_range(0, 3) == 0);
        serve(win, $urandom_range(0, 2));
        if (drop) begin
          if (win == 0) req1_valid = 1'b0; else req0_valid = 1'b0;
          @(negedge clk);
          chk("dropped_no_busy", {add_x1, add_cin}, 0);
          chk("dropped_no_rsp", rsp_valid, 0);
        end else begin
          serve(1 - win, 0);
        end
      end
    end

    // Reset in the middle of an operation
    mx1[0] = 64'h0123_4567_89AB_CDEF; mx2[0] = 64'd1; mcin[0] = 1'b0;
    drive(0);
    #1;
    chk("mid_rst_grant", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_s", rsp_s, 0);
    chk("mid_rst_add", {add_x1, add_x2, add_cin}, 0);
    chk("mid_rst_ready", req0_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    ptr_m = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", rsp_valid, 0);
    end
    for (int j = 0; j < 2; j++) begin
      mx1[j] = {$urandom, $urandom}; mx2[j] = {$urandom, $urandom}; mcin[j] = 1'b1;
      drive(j);
    end
    serve(0, 1);
    serve(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
